// File: rtl/dac_xy_axi.sv
// Vector display DAC sink: holds each accepted X/Y point while the beam settles, lights the guns
// for a dwell time, and parks the beam at mid-scale after a long idle. Option: DAC_XY_SETTLE_BLANK_EN.
module dac_xy_axi #(
    parameter int DATA_BITS     = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int DWELL_CYCLES  = 2,
    parameter int IDLE_TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 tvalid,
    output logic                 tready,
    input  logic [DATA_BITS-1:0] adc_x,
    input  logic [DATA_BITS-1:0] adc_y,
    input  logic                 adc_red,
    input  logic                 adc_grn,
    input  logic                 adc_blu,
    output logic [DATA_BITS-1:0] dac_x,
    output logic [DATA_BITS-1:0] dac_y,
    output logic                 dac_red,
    output logic                 dac_grn,
    output logic                 dac_blu,
    output logic                 busy
);

    localparam int MAX_SD = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int MAXC   = (MAX_SD > IDLE_TIMEOUT) ? MAX_SD : IDLE_TIMEOUT;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0]        S_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]        D_LD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]        T_LD = CW'(IDLE_TIMEOUT);
    localparam logic [DATA_BITS-1:0] MID  = DATA_BITS'(1) << (DATA_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DWELL} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] x_q, x_d, y_q, y_d;
    logic [2:0]           col_q, col_d;
    logic [2:0]           gun_q, gun_d;
    logic                 busy_q, idle_q;
    logic                 accept;

    assign tready = idle_q & enable;
    assign accept = tvalid & tready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    x_d   = adc_x;
                    y_d   = adc_y;
                    col_d = {adc_red, adc_grn, adc_blu};
                    if (adc_x != x_q || adc_y != y_q) begin
                        state_d = S_SETTLE;
                        cnt_d   = S_LD;
                    end else begin
                        state_d = S_DWELL;
                        cnt_d   = D_LD;
                    end
                end else if (cnt_q != '0) begin
                    // In IDLE the counter is the remaining idle budget; it parks once on 1->0 and then holds.
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        x_d = MID;
                        y_d = MID;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_DWELL;
                    cnt_d   = D_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DWELL: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = T_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = T_LD;
            end
        endcase

        gun_d = 3'b000;
        if (state_d == S_DWELL) gun_d = col_d;
`ifndef DAC_XY_SETTLE_BLANK_EN
        if (state_d == S_SETTLE) gun_d = col_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= T_LD;
            x_q     <= MID;
            y_q     <= MID;
            col_q   <= 3'b000;
            gun_q   <= 3'b000;
            busy_q  <= 1'b0;
            idle_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            gun_q   <= gun_d;
            busy_q  <= (state_d != S_IDLE);
            idle_q  <= (state_d == S_IDLE);
        end
    end

    assign dac_x   = x_q;
    assign dac_y   = y_q;
    assign dac_red = gun_q[2];
    assign dac_grn = gun_q[1];
    assign dac_blu = gun_q[0];
    assign busy    = busy_q;

endmodule
